// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard receiver.
//   SC_BREAK / SC_EXT  - Set-2 prefix bytes (break and extended)
//   dec_state_t        - prefix-tracking decoder states
//   key_map_t          - lookup result (hit flag + ASCII)
//   scan_to_ascii()    - Set-2 make code -> lowercase ASCII
package ps2_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_t;

    typedef struct packed {
        logic       hit;
        logic [7:0] ascii;
    } key_map_t;

    function automatic key_map_t scan_to_ascii(input logic [7:0] code);
        key_map_t r;
        r.hit   = 1'b1;
        r.ascii = 8'h00;
        case (code)
            8'h1C: r.ascii = 8'h61;  8'h32: r.ascii = 8'h62;
            8'h21: r.ascii = 8'h63;  8'h23: r.ascii = 8'h64;
            8'h24: r.ascii = 8'h65;  8'h2B: r.ascii = 8'h66;
            8'h34: r.ascii = 8'h67;  8'h33: r.ascii = 8'h68;
            8'h43: r.ascii = 8'h69;  8'h3B: r.ascii = 8'h6A;
            8'h42: r.ascii = 8'h6B;  8'h4B: r.ascii = 8'h6C;
            8'h3A: r.ascii = 8'h6D;  8'h31: r.ascii = 8'h6E;
            8'h44: r.ascii = 8'h6F;  8'h4D: r.ascii = 8'h70;
            8'h15: r.ascii = 8'h71;  8'h2D: r.ascii = 8'h72;
            8'h1B: r.ascii = 8'h73;  8'h2C: r.ascii = 8'h74;
            8'h3C: r.ascii = 8'h75;  8'h2A: r.ascii = 8'h76;
            8'h1D: r.ascii = 8'h77;  8'h22: r.ascii = 8'h78;
            8'h35: r.ascii = 8'h79;  8'h1A: r.ascii = 8'h7A;
            8'h45: r.ascii = 8'h30;  8'h16: r.ascii = 8'h31;
            8'h1E: r.ascii = 8'h32;  8'h26: r.ascii = 8'h33;
            8'h25: r.ascii = 8'h34;  8'h2E: r.ascii = 8'h35;
            8'h36: r.ascii = 8'h36;  8'h3D: r.ascii = 8'h37;
            8'h3E: r.ascii = 8'h38;  8'h46: r.ascii = 8'h39;
            8'h29: r.ascii = 8'h20;
            default: r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 line receiver. Synchronises the raw lines, samples one bit per
// ps2_clk falling edge, assembles 11-bit frames and checks start/parity/stop.
//   clk, rst      system clock, async active-high reset
//   i_ps2_clk     raw PS/2 clock line
//   i_ps2_data    raw PS/2 data line
//   o_byte        last accepted data byte
//   o_byte_ready  one-cycle pulse when o_byte is loaded
module ps2_rx #(
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_ready
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]      r_clk_sync;
    logic [2:0]      r_data_sync;
    logic            r_clk_prev;
    logic [3:0]      r_bit_cnt;
    logic [9:0]      r_shift;
    logic [WD_W-1:0] r_wd_cnt;
    logic [7:0]      r_byte;
    logic            r_byte_ready;

    logic w_fall;
    logic w_bit;
    logic w_frame_ok;

    assign w_fall = r_clk_prev & ~r_clk_sync[2];
    assign w_bit  = r_data_sync[2];
    // r_shift holds bits 0..9 with the start bit at [0]; w_bit is the stop bit.
    assign w_frame_ok = ~r_shift[0] & w_bit & (^r_shift[9:1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync   <= '1;
            r_data_sync  <= '1;
            r_clk_prev   <= 1'b1;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_wd_cnt     <= '0;
            r_byte       <= '0;
            r_byte_ready <= 1'b0;
        end else begin
            r_clk_sync   <= {r_clk_sync[1:0], i_ps2_clk};
            r_data_sync  <= {r_data_sync[1:0], i_ps2_data};
            r_clk_prev   <= r_clk_sync[2];
            r_byte_ready <= 1'b0;
            if (w_fall) begin
                r_wd_cnt <= WD_W'(TIMEOUT_CYC - 1);
                if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt <= '0;
                    if (w_frame_ok) begin
                        r_byte       <= r_shift[8:1];
                        r_byte_ready <= 1'b1;
                    end
                end else begin
                    r_shift   <= {w_bit, r_shift[9:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else if (r_bit_cnt != 4'd0) begin
                // Watchdog: a stalled partial frame is dropped on terminal count.
                if (r_wd_cnt == '0) begin
                    r_bit_cnt <= '0;
                end else begin
                    r_wd_cnt <= r_wd_cnt - WD_W'(1);
                end
            end
        end
    end

    assign o_byte       = r_byte;
    assign o_byte_ready = r_byte_ready;

endmodule

// File: rtl/ps2_keyboard_fsm.sv
// ps2_keyboard_fsm: PS/2 keyboard decoder presenting the held key as ASCII.
//   clk, rst    system clock, async active-high reset
//   ps2_clk     raw PS/2 clock line
//   ps2_data    raw PS/2 data line
//   ascii       ASCII of the held key, else RELEASE_CODE
//   key_valid   one-cycle pulse when ascii is loaded from a make code
//
// state      | meaning
// ST_IDLE    | no prefix pending; make codes load ascii
// ST_EXT     | E0 seen; next byte is an extended key (ignored) or F0
// ST_BRK     | F0 seen; next byte is the released key
// ST_EXT_BRK | E0 F0 seen; next byte is an ignored extended release
module ps2_keyboard_fsm
    import ps2_pkg::*;
#(
    parameter logic [7:0] RELEASE_CODE = 8'h31,
    parameter int         TIMEOUT_CYC  = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ascii,
    output logic       key_valid
);

    logic [7:0] w_byte;
    logic       w_byte_ready;
    key_map_t   w_map;

    dec_state_t r_state;
    dec_state_t w_state_nxt;
    logic [7:0] r_ascii;
    logic [7:0] w_ascii_nxt;
    logic       r_key_valid;
    logic       w_kv_nxt;

    ps2_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_byte       (w_byte),
        .o_byte_ready (w_byte_ready)
    );

    assign w_map = scan_to_ascii(w_byte);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ascii     <= RELEASE_CODE;
            r_key_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ascii     <= w_ascii_nxt;
            r_key_valid <= w_kv_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ascii_nxt = r_ascii;
        w_kv_nxt    = 1'b0;
        if (w_byte_ready) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_byte == SC_EXT) begin
                        w_state_nxt = ST_EXT;
                    end else if (w_byte == SC_BREAK) begin
                        w_state_nxt = ST_BRK;
                    end else if (w_map.hit) begin
                        w_ascii_nxt = w_map.ascii;
                        w_kv_nxt    = 1'b1;
                    end
                end
                ST_EXT: begin
                    w_state_nxt = (w_byte == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                end
                ST_BRK: begin
                    w_state_nxt = ST_IDLE;
                    // Releasing a key other than the held one leaves ascii alone.
                    if (w_map.hit && (w_map.ascii == r_ascii)) begin
                        w_ascii_nxt = RELEASE_CODE;
                    end
                end
                ST_EXT_BRK: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign ascii     = r_ascii;
    assign key_valid = r_key_valid;

endmodule

// File: tb/tb_ps2_keyboard_fsm.sv
module tb_ps2_keyboard_fsm;

    localparam int         HALF    = 20;
    localparam int         TIMEOUT = 200;
    localparam logic [7:0] RELEASE = 8'h31;
    localparam int         WINDOW  = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] ascii;
    logic       key_valid;

    ps2_keyboard_fsm #(
        .RELEASE_CODE (RELEASE),
        .TIMEOUT_CYC  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ascii     (ascii),
        .key_valid (key_valid)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: held key, the value before the latest frame, and
    // whether that frame should have produced a key_valid pulse.
    logic [7:0] m_ascii = RELEASE;
    logic [7:0] m_prev = RELEASE;
    int         m_kv_exp = 0;
    int         stop_cyc = -1000;
    bit         pend_e0 = 0;
    bit         pend_f0 = 0;
    int         keymap[256];
    int         kv_seen = 0;
    int         kv_total = 0;

    string      key_chars = "abcdefghijklmnopqrstuvwxyz0123456789 ";
    logic [7:0] key_codes[37] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h45, 8'h16, 8'h1E, 8'h26,
        8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h29};

    task automatic chk(input string name, input bit ok, input int act, input int exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_ascii  = RELEASE;
        m_prev   = RELEASE;
        m_kv_exp = 0;
        pend_e0  = 0;
        pend_f0  = 0;
        stop_cyc = -1000;
    endtask

    // Applies one complete frame to the model at the stop-bit falling edge.
    task automatic model_frame(input logic [7:0] b, input bit good);
        m_prev   = m_ascii;
        m_kv_exp = 0;
        stop_cyc = cyc;
        if (good) begin
            if (b == 8'hE0 && !pend_e0 && !pend_f0) begin
                pend_e0 = 1;
            end else if (b == 8'hF0 && !pend_f0) begin
                pend_f0 = 1;
            end else begin
                if (pend_e0) begin
                    // extended keys never affect ascii
                end else if (pend_f0) begin
                    if (keymap[b] >= 0 && keymap[b] == int'(m_ascii)) m_ascii = RELEASE;
                end else if (keymap[b] >= 0) begin
                    m_ascii  = 8'(keymap[b]);
                    m_kv_exp = 1;
                end
                pend_e0 = 0;
                pend_f0 = 0;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] frame;
        frame = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); #2;
            ps2_data = frame[i];
            repeat (HALF) @(posedge clk);
            #2;
            ps2_clk = 1'b0;
            if (i == 10) model_frame(b, !bad_par);
            repeat (HALF) @(posedge clk);
            #2;
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic pin(input string name, input logic [7:0] exp);
        #1;
        chk(name, ascii == exp, int'(ascii), int'(exp));
        chk({name, "_model"}, m_ascii == exp, int'(m_ascii), int'(exp));
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin : compare
        int age;
        if (rst) begin
            chk("reset_ascii", ascii == RELEASE, int'(ascii), int'(RELEASE));
            chk("reset_kv", key_valid == 1'b0, int'(key_valid), 0);
            kv_seen = 0;
        end else begin
            if (key_valid) kv_total <= kv_total + 1;
            age = cyc - stop_cyc;
            if (age == 0) kv_seen = 0;
            if (age >= 0 && age <= WINDOW) begin
                if (key_valid) kv_seen++;
                chk("ascii_window", ascii == m_ascii || ascii == m_prev, int'(ascii), int'(m_ascii));
                if (age == WINDOW) chk("kv_pulses", kv_seen == m_kv_exp, kv_seen, m_kv_exp);
            end else begin
                chk("ascii", ascii == m_ascii, int'(ascii), int'(m_ascii));
                chk("kv_idle", key_valid == 1'b0, int'(key_valid), 0);
            end
        end
    end

    initial begin
        int kv_before;
        logic [7:0] pool[6] = '{8'h1C, 8'h32, 8'h45, 8'h29, 8'h75, 8'h3A};
        logic [7:0] b;
        int sel;

        for (int i = 0; i < 256; i++) keymap[i] = -1;
        for (int i = 0; i < 37; i++) keymap[key_codes[i]] = int'(key_chars[i]);

        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (5) @(posedge clk);
        pin("idle", 8'h31);

        send_frame(8'h1C, 0, 11);
        pin("make_a", 8'h61);
        chk("kv_count_a", kv_total == 1, kv_total, 1);

        send_frame(8'hF0, 0, 11);
        send_frame(8'h1C, 0, 11);
        pin("break_a", 8'h31);

        send_frame(8'h1C, 0, 11);
        send_frame(8'hF0, 0, 11);
        send_frame(8'h32, 0, 11);
        pin("break_other", 8'h61);

        send_frame(8'h1C, 1, 11);
        pin("bad_parity", 8'h61);
        send_frame(8'h32, 0, 11);
        pin("make_b", 8'h62);

        kv_before = kv_total;
        send_frame(8'hE0, 0, 11);
        send_frame(8'h75, 0, 11);
        send_frame(8'hE0, 0, 11);
        send_frame(8'hF0, 0, 11);
        send_frame(8'h75, 0, 11);
        pin("extended", 8'h62);
        chk("kv_extended", kv_total == kv_before, kv_total, kv_before);
        send_frame(8'h45, 0, 11);
        pin("make_0", 8'h30);

        send_frame(8'h29, 0, 5);
        #2 rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk("reset_now", ascii == 8'h31, int'(ascii), 32'h31);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (5) @(posedge clk);
        send_frame(8'h29, 0, 11);
        pin("space", 8'h20);

        send_frame(8'h1C, 0, 4);
        repeat (TIMEOUT + 50) @(posedge clk);
        send_frame(8'h3A, 0, 11);
        pin("after_timeout", 8'h6D);

        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 45)      b = pool[$urandom_range(0, 5)];
            else if (sel < 62) b = 8'hF0;
            else if (sel < 72) b = 8'hE0;
            else if (sel < 85) b = key_codes[$urandom_range(0, 36)];
            else               b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 14) == 0) begin
                send_frame(b, 0, int'($urandom_range(1, 10)));
                repeat (TIMEOUT + 50) @(posedge clk);
            end else begin
                send_frame(b, $urandom_range(0, 7) == 0, 11);
            end
        end

        repeat (20) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
